// File: rtl/cost_port_arbiter.sv
// Round-robin arbiter sharing one cost-table read port between two search engines.
// Grants whole bursts, muxes the granted engine's address, and tags returned Cost per engine.
module cost_port_arbiter #(
    parameter int MAX_BURST = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    input  logic [1:0] LAST,
    input  logic [2:0] W0,
    input  logic [2:0] J0,
    input  logic [2:0] W1,
    input  logic [2:0] J1,
    output logic [1:0] GNT,
    output logic [1:0] CVAL,
    output logic [6:0] COST,
    output logic [2:0] W,
    output logic [2:0] J,
    output logic       T_REQ,
    input  logic [6:0] Cost
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] cval_q, cval_d;
    logic [1:0] issue_s;
    logic       sel_s;

    // Issue qualification and address mux onto the table port.
    always_comb begin
        issue_s = gnt_q & REQ;
        W       = 3'd0;
        J       = 3'd0;
        T_REQ   = 1'b0;
        if (issue_s[0]) begin
            W     = W0;
            J     = J0;
            T_REQ = 1'b1;
        end else if (issue_s[1]) begin
            W     = W1;
            J     = J1;
            T_REQ = 1'b1;
        end else begin
            W     = 3'd0;
            J     = 3'd0;
            T_REQ = 1'b0;
        end
    end

    // Next-state: round-robin pick in IDLE, burst termination while granted.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_s   = (state_q == GRANT1);
        case (state_q)
            IDLE: begin
                if (REQ[ptr_q]) begin
                    state_d = ptr_q ? GRANT1 : GRANT0;
                    ptr_d   = ~ptr_q;
                    cnt_d   = 4'd0;
                end else if (REQ[~ptr_q]) begin
                    state_d = ptr_q ? GRANT0 : GRANT1;
                    ptr_d   = ptr_q;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT0, GRANT1: begin
                if (!REQ[sel_s]) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    // LAST on the MAX_BURST-th read is the same single end event
                    if (LAST[sel_s] || (cnt_d == MAX_CNT)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        gnt_d  = {(state_d == GRANT1), (state_d == GRANT0)};
        cval_d = issue_s;
    end

    // State, pointer, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            gnt_q   <= 2'b00;
            cval_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            cval_q  <= cval_d;
        end
    end

    assign GNT  = gnt_q;
    assign CVAL = cval_q;
    assign COST = Cost;

endmodule

// File: tb/tb_cost_port_arbiter.sv
// Randomized bench for cost_port_arbiter: burst-level reference model feeds a
// return scoreboard; a negedge monitor checks CVAL/COST against it.
module tb_cost_port_arbiter;

    localparam int MAXB = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] REQ, LAST;
    logic [2:0] W0, J0, W1, J1;
    logic [1:0] GNT, CVAL;
    logic [6:0] COST;
    logic [2:0] W, J;
    logic       T_REQ;
    logic [6:0] Cost;

    cost_port_arbiter #(.MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .LAST(LAST),
        .W0(W0), .J0(J0), .W1(W1), .J1(J1),
        .GNT(GNT), .CVAL(CVAL), .COST(COST), .W(W), .J(J),
        .T_REQ(T_REQ), .Cost(Cost)
    );

    always #5 CLK = ~CLK;

    // Cost table: data appears the cycle after the address is strobed.
    logic [6:0] mem [64];
    logic [6:0] cost_r;
    always @(posedge CLK) begin
        if (T_REQ) cost_r <= mem[{W, J}];
    end
    assign Cost = cost_r;

    typedef struct {
        int         due;
        int         eng;
        logic [6:0] cost;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Reference model: who owns the port, reads done in this burst, who goes first next.
    int owner = -1;
    int nreads = 0;
    int first = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Return-path monitor.
    initial begin
        exp_t e;
        wait (cyc >= 1);
        forever begin
            @(negedge CLK);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("cval", {30'd0, CVAL}, (e.eng == 0) ? 32'd1 : 32'd2);
                check("cost", {25'd0, COST}, {25'd0, e.cost});
            end else begin
                check("cval_quiet", {30'd0, CVAL}, 32'd0);
            end
        end
    end

    initial begin
        int mode, iss, nxt;
        logic [1:0] r_req, r_last;
        logic [2:0] r_w[2], r_j[2];
        logic r_rst;
        logic [1:0] exp_gnt;

        for (int i = 0; i < 64; i++) mem[i] = 7'($urandom);
        REQ = 2'b00; LAST = 2'b00; RST = 1'b1;
        W0 = 3'd0; J0 = 3'd0; W1 = 3'd0; J1 = 3'd0;

        for (int c = 0; c < 2420; c++) begin
            mode = (c / 600) % 4;
            if (c < 2) begin
                RST = 1'b1; REQ = 2'b11; LAST = 2'b00;
            end else if (c >= 2400) begin
                RST = 1'b0; REQ = 2'b00; LAST = 2'b00;
            end else begin
                RST = ($urandom_range(0, 199) == 0);
                for (int e = 0; e < 2; e++) begin
                    case (mode)
                        0: begin
                            if ($urandom_range(0, 9) == 0) REQ[e] = ~REQ[e];
                            LAST[e] = ($urandom_range(0, 4) == 0);
                        end
                        1: begin
                            REQ[e] = REQ[e] ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 2) == 0);
                            LAST[e] = ($urandom_range(0, 7) == 0);
                        end
                        2: begin
                            REQ[e] = REQ[e] ? ($urandom_range(0, 59) != 0) : 1'b1;
                            LAST[e] = 1'b0;
                        end
                        default: begin
                            REQ[e] = $urandom_range(0, 1);
                            LAST[e] = $urandom_range(0, 1);
                        end
                    endcase
                end
            end
            W0 = 3'($urandom); J0 = 3'($urandom);
            W1 = 3'($urandom); J1 = 3'($urandom);
            r_rst = RST; r_req = REQ; r_last = LAST;
            r_w[0] = W0; r_j[0] = J0; r_w[1] = W1; r_j[1] = J1;

            #1;
            iss = (owner >= 0 && r_req[owner]) ? owner : -1;
            if (cyc > 0) begin
                exp_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
                check("gnt",   {30'd0, GNT}, {30'd0, exp_gnt});
                check("t_req", {31'd0, T_REQ}, (iss >= 0) ? 32'd1 : 32'd0);
                check("w", {29'd0, W}, (iss >= 0) ? {29'd0, r_w[iss]} : 32'd0);
                check("j", {29'd0, J}, (iss >= 0) ? {29'd0, r_j[iss]} : 32'd0);
            end

            @(posedge CLK);
            cyc++;
            if (r_rst) begin
                owner = -1; nreads = 0; first = 0;
            end else begin
                if (iss >= 0) sb.push_back('{cyc, iss, mem[{r_w[iss], r_j[iss]}]});
                if (owner < 0) begin
                    nxt = r_req[first] ? first : (r_req[1 - first] ? 1 - first : -1);
                    if (nxt >= 0) begin
                        owner = nxt; nreads = 0; first = 1 - nxt;
                    end
                end else if (!r_req[owner]) begin
                    owner = -1;
                end else begin
                    nreads++;
                    if (r_last[owner] || nreads == MAXB) owner = -1;
                end
            end
            #1;
        end

        @(negedge CLK);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
